twd_mul_triv: RTL and testbench
===============================

# twd_mul_triv

Parametrised trivial-twiddle rotator for pipelined radix-2 FFT stages. It sits directly after a butterfly bank and passes the sum outputs through unchanged. The difference outputs are rotated by W ∈ {1, −j, −1, +j}, selected per input block by an internal block counter. The rotated samples are registered with one cycle of latency, the negations saturate, and a frame-boundary strobe marks the last block of each frame.

## Interface
Parameters:
- WIDTH, 9: MSB index of every data sample; samples are signed [WIDTH:0], format <4.6> at default.
- LANES, 16: parallel butterfly lanes per block.
- CNT_W, 4: block-counter width; a frame is 2^CNT_W blocks.
- SEG_SHIFT, 3: twiddle index = block count >> SEG_SHIFT.
- MODE, 0: 0 = two-twiddle set {1, −j} using idx[0]; 1 = four-twiddle set {1, −j, −1, +j} using idx[1:0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_valid  in  1  input block valid; one block per cycle while high, no backpressure.
- i_clear  in  1  synchronous block-counter clear.
- i_sum_re / i_sum_im  in  [WIDTH:0] x LANES  butterfly sum outputs.
- i_diff_re / i_diff_im  in  [WIDTH:0] x LANES  butterfly difference outputs.
- o_valid  out  1  output block valid.
- o_sum_re / o_sum_im  out  [WIDTH:0] x LANES  registered sum passthrough.
- o_diff_re / o_diff_im  out  [WIDTH:0] x LANES  registered rotated difference.
- o_blk_cnt  out  [CNT_W-1:0]  block count used for the current output block.
- o_frame_done  out  1  high with o_valid for the last block of a frame.

## Operation
- Block counter cnt (CNT_W bits):
  - Increments by 1 for each cycle with i_valid = 1.
  - Wraps from 2^CNT_W−1 to 0.
  - Holds its value while i_valid = 0.
- The effective count for the current cycle, eff_cnt, is 0 when i_clear = 1 and cnt otherwise.
- i_clear behaviour:
  - i_clear = 1 with i_valid = 1: the block is processed with eff_cnt = 0, and cnt becomes 1.
  - i_clear = 1 with i_valid = 0: cnt becomes 0.
- Twiddle index: idx = eff_cnt >> SEG_SHIFT.
  - MODE 0: sel = {1'b0, idx[0]}.
  - MODE 1: sel = idx[1:0].
- Rotation per lane, with (re, im) = the lane's diff sample:
  - sel 0: (re, im).
  - sel 1 (−j): (im, −re).
  - sel 2 (−1): (−re, −im).
  - sel 3 (+j): (−im, re).
- Negation saturates: −(−2^WIDTH) yields 2^WIDTH−1. All other values negate exactly. No other arithmetic and no width growth.
- Sum lanes are registered unmodified.
- o_blk_cnt is registered from eff_cnt.
- o_frame_done is set to i_valid & (eff_cnt == 2^CNT_W−1).
- While i_valid = 0, data and count output registers hold their previous values, and o_valid and o_frame_done drop to 0.

## Timing
- Latency is 1 cycle: a block accepted at edge N appears at the outputs after edge N, with o_valid = 1 during cycle N+1.
- Back-to-back valid blocks give full throughput of one block per cycle.
- Reset (rstn = 0, asynchronous): cnt = 0, o_valid = 0, o_frame_done = 0, o_blk_cnt = 0, and all data outputs = 0.
- The first valid block after reset uses count 0 (sel 0).
- Reset in the middle of a frame discards any in-flight output block. No output is produced until i_valid is seen again after rstn deasserts.
- Counter wrap: the block at count 2^CNT_W−1 raises o_frame_done. The next valid block uses count 0 with o_frame_done = 0.
- Gaps in i_valid do not advance the counter, so sel depends only on the number of accepted blocks.
- i_clear during the last block of a frame: that block uses count 0, and o_frame_done = 0.

## Test plan
- Reset, then 16 valid blocks with defaults (MODE 0, SHIFT 3, CNT_W 4) and diff = (100, −50) in all lanes:
  - Blocks 0–7 output (100, −50).
  - Blocks 8–15 output (−50, −100).
  - Sums are unchanged in every block.
  - o_frame_done is high only on block 15.
  - o_blk_cnt runs 0..15, then 0.
- MODE 1, CNT_W 4, SHIFT 2, diff = (3, 7): the four groups of 4 blocks yield (3, 7), (7, −3), (−3, −7), (−7, 3).
- Saturation, MODE 1 at sel 2, diff = (−512, −512) with WIDTH 9: output (511, 511). At sel 1 with diff = (5, −512): output (−512, −5).
- i_valid pattern 1,0,0,1 with diff = (1, 2): two output blocks with o_blk_cnt 0 and 1, o_valid high exactly one cycle after each accepted input, and outputs holding in between.
- i_clear asserted with i_valid at cnt = 9: that block outputs o_blk_cnt 0 with sel 0, and the next block outputs o_blk_cnt 1.
- rstn pulsed low asynchronously at cnt = 5 during a valid stream:
  - All outputs read 0 immediately.
  - o_valid stays 0 until the first post-reset valid block.
  - That block reports o_blk_cnt 0.

Source files
------------

// File: rtl/twd_mul_triv_if.sv
// Block-level bus for the trivial-twiddle rotator: one butterfly block in,
// one registered (sum, rotated diff) block out, no backpressure.
interface twd_mul_triv_if #(
    parameter int WIDTH = 9,
    parameter int LANES = 16,
    parameter int CNT_W = 4
);
    logic                    i_valid;
    logic                    i_clear;
    logic signed [WIDTH:0]   i_sum_re  [LANES];
    logic signed [WIDTH:0]   i_sum_im  [LANES];
    logic signed [WIDTH:0]   i_diff_re [LANES];
    logic signed [WIDTH:0]   i_diff_im [LANES];

    logic                    o_valid;
    logic signed [WIDTH:0]   o_sum_re  [LANES];
    logic signed [WIDTH:0]   o_sum_im  [LANES];
    logic signed [WIDTH:0]   o_diff_re [LANES];
    logic signed [WIDTH:0]   o_diff_im [LANES];
    logic [CNT_W-1:0]        o_blk_cnt;
    logic                    o_frame_done;

    modport master (
        output i_valid, i_clear, i_sum_re, i_sum_im, i_diff_re, i_diff_im,
        input  o_valid, o_sum_re, o_sum_im, o_diff_re, o_diff_im, o_blk_cnt, o_frame_done
    );

    modport slave (
        input  i_valid, i_clear, i_sum_re, i_sum_im, i_diff_re, i_diff_im,
        output o_valid, o_sum_re, o_sum_im, o_diff_re, o_diff_im, o_blk_cnt, o_frame_done
    );
endinterface

// File: rtl/twd_mul_triv.sv
// Trivial-twiddle rotator: passes butterfly sums through and rotates the
// differences by 1, -j, -1 or +j chosen from a per-block counter.
module twd_mul_triv #(
    parameter int WIDTH     = 9,
    parameter int LANES     = 16,
    parameter int CNT_W     = 4,
    parameter int SEG_SHIFT = 3,
    parameter int MODE      = 0
) (
    input  logic          clk,
    input  logic          rstn,
    twd_mul_triv_if.slave bus
);
    localparam logic signed [WIDTH:0] MIN_VAL = {1'b1, {WIDTH{1'b0}}};
    localparam logic signed [WIDTH:0] MAX_VAL = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        ROT_ONE     = 2'd0,
        ROT_NEG_J   = 2'd1,
        ROT_NEG_ONE = 2'd2,
        ROT_POS_J   = 2'd3
    } rot_e;

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      eff_cnt;
    logic                  sel_lo;
    logic                  sel_hi;
    rot_e                  sel;
    logic signed [WIDTH:0] rot_re [LANES];
    logic signed [WIDTH:0] rot_im [LANES];

    // The only overflowing negation is of the most negative code; clamp it.
    function automatic logic signed [WIDTH:0] neg_sat(input logic signed [WIDTH:0] x);
        return (x == MIN_VAL) ? MAX_VAL : -x;
    endfunction

    assign eff_cnt = bus.i_clear ? '0 : cnt;

    // Twiddle select bits are picked straight out of the count; bits shifted
    // beyond the counter width read as zero.
    if (SEG_SHIFT < CNT_W) begin : g_sel_lo
        assign sel_lo = eff_cnt[SEG_SHIFT];
    end else begin : g_sel_lo_zero
        assign sel_lo = 1'b0;
    end

    if (MODE == 1 && SEG_SHIFT + 1 < CNT_W) begin : g_sel_hi
        assign sel_hi = eff_cnt[SEG_SHIFT+1];
    end else begin : g_sel_hi_zero
        assign sel_hi = 1'b0;
    end

    assign sel = rot_e'({sel_hi, sel_lo});

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rot_re[l] = bus.i_diff_re[l];
            rot_im[l] = bus.i_diff_im[l];
            case (sel)
                ROT_ONE: ;
                ROT_NEG_J: begin
                    rot_re[l] = bus.i_diff_im[l];
                    rot_im[l] = neg_sat(bus.i_diff_re[l]);
                end
                ROT_NEG_ONE: begin
                    rot_re[l] = neg_sat(bus.i_diff_re[l]);
                    rot_im[l] = neg_sat(bus.i_diff_im[l]);
                end
                ROT_POS_J: begin
                    rot_re[l] = neg_sat(bus.i_diff_im[l]);
                    rot_im[l] = bus.i_diff_re[l];
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (bus.i_valid) begin
            cnt <= eff_cnt + CNT_W'(1);
        end else if (bus.i_clear) begin
            cnt <= '0;
        end
    end

    // NOTE: the data registers are real outputs, not storage arrays, so they
    // are reset along with the control flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.o_valid      <= 1'b0;
            bus.o_frame_done <= 1'b0;
            bus.o_blk_cnt    <= '0;
            for (int l = 0; l < LANES; l++) begin
                bus.o_sum_re[l]  <= '0;
                bus.o_sum_im[l]  <= '0;
                bus.o_diff_re[l] <= '0;
                bus.o_diff_im[l] <= '0;
            end
        end else begin
            bus.o_valid      <= bus.i_valid;
            bus.o_frame_done <= bus.i_valid & (eff_cnt == '1);
            if (bus.i_valid) begin
                bus.o_blk_cnt <= eff_cnt;
                for (int l = 0; l < LANES; l++) begin
                    bus.o_sum_re[l]  <= bus.i_sum_re[l];
                    bus.o_sum_im[l]  <= bus.i_sum_im[l];
                    bus.o_diff_re[l] <= rot_re[l];
                    bus.o_diff_im[l] <= rot_im[l];
                end
            end
        end
    end
endmodule

// File: tb/tb_twd_mul_triv.sv
// Bench for twd_mul_triv: a MODE 0 / SHIFT 3 instance and a MODE 1 / SHIFT 2
// instance share stimulus and are checked against a complex-multiply model.
module tb_twd_mul_triv;
    localparam int W     = 9;
    localparam int L     = 16;
    localparam int CW    = 4;
    localparam int FRAME = 1 << CW;
    localparam int MAXV  = (1 << W) - 1;
    localparam int MINV  = -(1 << W);

    typedef logic signed [W:0] samp_t;

    typedef struct {
        bit valid;
        bit clear;
        int dre;
        int dim;
        int dut;
        int e_re;
        int e_im;
        int e_blk;
        bit e_done;
    } vec_t;

    bit   clk = 1'b0;
    logic rstn;

    twd_mul_triv_if #(.WIDTH(W), .LANES(L), .CNT_W(CW)) bus0 ();
    twd_mul_triv_if #(.WIDTH(W), .LANES(L), .CNT_W(CW)) bus1 ();

    twd_mul_triv #(.WIDTH(W), .LANES(L), .CNT_W(CW), .SEG_SHIFT(3), .MODE(0)) dut0 (
        .clk(clk), .rstn(rstn), .bus(bus0));
    twd_mul_triv #(.WIDTH(W), .LANES(L), .CNT_W(CW), .SEG_SHIFT(2), .MODE(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state and expected registered outputs, per instance.
    int m_mode  [2] = '{0, 1};
    int m_shift [2] = '{3, 2};
    int m_cnt   [2];
    int e_valid [2];
    int e_done  [2];
    int e_blk   [2];
    int e_dre   [2][L];
    int e_dim   [2][L];
    int e_sre   [2][L];
    int e_sim   [2][L];
    int cur_sre [L];
    int cur_sim [L];

    integer a_valid [2];
    integer a_done  [2];
    integer a_blk   [2];
    integer a_dre   [2][L];
    integer a_dim   [2][L];
    integer a_sre   [2][L];
    integer a_sim   [2][L];

    task automatic check(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Rotation as a complex multiply by (-j)^q, then clamped to the sample range.
    function automatic int rot_ref(input int mode, input int shift, input int k,
                                   input int re, input int im, input bit want_im);
        int q, wr, wi, res;
        q = (k >> shift) % ((mode == 1) ? 4 : 2);
        case (q)
            0:       begin wr = 1;  wi = 0;  end
            1:       begin wr = 0;  wi = -1; end
            2:       begin wr = -1; wi = 0;  end
            default: begin wr = 0;  wi = 1;  end
        endcase
        res = want_im ? (wr * im + wi * re) : (wr * re - wi * im);
        if (res > MAXV) res = MAXV;
        if (res < MINV) res = MINV;
        return res;
    endfunction

    function automatic int rand_sample();
        if ($urandom_range(0, 7) == 0) return MINV;
        if ($urandom_range(0, 7) == 0) return MAXV;
        return int'($urandom_range(0, 2 * MAXV + 1)) + MINV;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; e_valid[d] = 0; e_done[d] = 0; e_blk[d] = 0;
            for (int l = 0; l < L; l++) begin
                e_dre[d][l] = 0; e_dim[d][l] = 0; e_sre[d][l] = 0; e_sim[d][l] = 0;
            end
        end
    endtask

    task automatic sample();
        a_valid[0] = bus0.o_valid;      a_valid[1] = bus1.o_valid;
        a_done[0]  = bus0.o_frame_done; a_done[1]  = bus1.o_frame_done;
        a_blk[0]   = bus0.o_blk_cnt;    a_blk[1]   = bus1.o_blk_cnt;
        for (int l = 0; l < L; l++) begin
            a_dre[0][l] = bus0.o_diff_re[l]; a_dre[1][l] = bus1.o_diff_re[l];
            a_dim[0][l] = bus0.o_diff_im[l]; a_dim[1][l] = bus1.o_diff_im[l];
            a_sre[0][l] = bus0.o_sum_re[l];  a_sre[1][l] = bus1.o_sum_re[l];
            a_sim[0][l] = bus0.o_sum_im[l];  a_sim[1][l] = bus1.o_sum_im[l];
        end
    endtask

    task automatic compare_model();
        sample();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d o_valid", d), a_valid[d], e_valid[d]);
            check($sformatf("dut%0d o_frame_done", d), a_done[d], e_done[d]);
            check($sformatf("dut%0d o_blk_cnt", d), a_blk[d], e_blk[d]);
            for (int l = 0; l < L; l++) begin
                check($sformatf("dut%0d diff_re[%0d]", d, l), a_dre[d][l], e_dre[d][l]);
                check($sformatf("dut%0d diff_im[%0d]", d, l), a_dim[d][l], e_dim[d][l]);
                check($sformatf("dut%0d sum_re[%0d]", d, l), a_sre[d][l], e_sre[d][l]);
                check($sformatf("dut%0d sum_im[%0d]", d, l), a_sim[d][l], e_sim[d][l]);
            end
        end
    endtask

    // One cycle: drive at the falling edge, advance the model, compare after the rise.
    task automatic apply(input bit v, input bit c, input int dre, input int dim, input bit rnd);
        int eff [2];
        @(negedge clk);
        bus0.i_valid = v; bus1.i_valid = v;
        bus0.i_clear = c; bus1.i_clear = c;
        for (int d = 0; d < 2; d++) eff[d] = c ? 0 : m_cnt[d];
        for (int l = 0; l < L; l++) begin
            int r, i;
            r = rnd ? rand_sample() : dre;
            i = rnd ? rand_sample() : dim;
            cur_sre[l] = rand_sample();
            cur_sim[l] = rand_sample();
            bus0.i_diff_re[l] = samp_t'(r); bus1.i_diff_re[l] = samp_t'(r);
            bus0.i_diff_im[l] = samp_t'(i); bus1.i_diff_im[l] = samp_t'(i);
            bus0.i_sum_re[l] = samp_t'(cur_sre[l]); bus1.i_sum_re[l] = samp_t'(cur_sre[l]);
            bus0.i_sum_im[l] = samp_t'(cur_sim[l]); bus1.i_sum_im[l] = samp_t'(cur_sim[l]);
            if (v) begin
                for (int d = 0; d < 2; d++) begin
                    e_dre[d][l] = rot_ref(m_mode[d], m_shift[d], eff[d], r, i, 1'b0);
                    e_dim[d][l] = rot_ref(m_mode[d], m_shift[d], eff[d], r, i, 1'b1);
                    e_sre[d][l] = cur_sre[l];
                    e_sim[d][l] = cur_sim[l];
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            e_valid[d] = v;
            e_done[d]  = (v && eff[d] == FRAME - 1) ? 1 : 0;
            if (v) begin
                e_blk[d] = eff[d];
                m_cnt[d] = (eff[d] + 1) % FRAME;
            end else if (c) begin
                m_cnt[d] = 0;
            end
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // Spec-literal expectations for one instance, all lanes.
    task automatic check_blk(input int d, input string tag, input int vld, input int done,
                             input int blk, input int re, input int im);
        check($sformatf("%s dut%0d valid", tag, d), a_valid[d], vld);
        check($sformatf("%s dut%0d frame_done", tag, d), a_done[d], done);
        check($sformatf("%s dut%0d blk_cnt", tag, d), a_blk[d], blk);
        for (int l = 0; l < L; l++) begin
            check($sformatf("%s dut%0d re[%0d]", tag, d, l), a_dre[d][l], re);
            check($sformatf("%s dut%0d im[%0d]", tag, d, l), a_dim[d][l], im);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   gre [4] = '{3, 7, -3, -7};
        int   gim [4] = '{7, -3, -7, 3};

        for (int b = 0; b <= 16; b++)
            vecs.push_back('{1'b1, 1'b0, 100, -50, 0,
                             (b < 8 || b == 16) ? 100 : -50,
                             (b < 8 || b == 16) ? -50 : -100,
                             b % 16, b == 15});
        for (int b = 0; b < 16; b++)
            vecs.push_back('{1'b1, b == 0, 3, 7, 1, gre[b / 4], gim[b / 4], b, b == 15});

        rstn = 1'b0;
        bus0.i_valid = 1'b0; bus1.i_valid = 1'b0;
        bus0.i_clear = 1'b0; bus1.i_clear = 1'b0;
        for (int l = 0; l < L; l++) begin
            bus0.i_sum_re[l] = '0;  bus1.i_sum_re[l] = '0;
            bus0.i_sum_im[l] = '0;  bus1.i_sum_im[l] = '0;
            bus0.i_diff_re[l] = '0; bus1.i_diff_re[l] = '0;
            bus0.i_diff_im[l] = '0; bus1.i_diff_im[l] = '0;
        end
        model_reset();
        #12;
        compare_model();
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[k]) begin
            apply(vecs[k].valid, vecs[k].clear, vecs[k].dre, vecs[k].dim, 1'b0);
            check_blk(vecs[k].dut, $sformatf("vec%0d", k), 1, vecs[k].e_done,
                      vecs[k].e_blk, vecs[k].e_re, vecs[k].e_im);
            for (int l = 0; l < L; l++)
                check($sformatf("vec%0d sum_re[%0d]", k, l), a_sre[vecs[k].dut][l], cur_sre[l]);
        end

        // Saturating negation at sel 1 and sel 2 of the four-twiddle instance.
        apply(1'b1, 1'b1, 0, 0, 1'b1);
        repeat (3) apply(1'b1, 1'b0, 0, 0, 1'b1);
        apply(1'b1, 1'b0, 5, MINV, 1'b0);
        check_blk(1, "sat_sel1", 1, 0, 4, MINV, -5);
        repeat (3) apply(1'b1, 1'b0, 0, 0, 1'b1);
        apply(1'b1, 1'b0, MINV, MINV, 1'b0);
        check_blk(1, "sat_sel2", 1, 0, 8, MAXV, MAXV);
        check_blk(0, "sat_negj", 1, 0, 8, MINV, MAXV);

        // Gapped valid: outputs hold and the count advances only on accepted blocks.
        apply(1'b0, 1'b1, 0, 0, 1'b1);
        apply(1'b1, 1'b0, 1, 2, 1'b0);
        check_blk(0, "gap_a", 1, 0, 0, 1, 2);
        apply(1'b0, 1'b0, 77, 77, 1'b0);
        check_blk(0, "gap_hold1", 0, 0, 0, 1, 2);
        apply(1'b0, 1'b0, 77, 77, 1'b0);
        check_blk(0, "gap_hold2", 0, 0, 0, 1, 2);
        apply(1'b1, 1'b0, 1, 2, 1'b0);
        check_blk(0, "gap_b", 1, 0, 1, 1, 2);

        // Clear mid-frame at count 9.
        apply(1'b0, 1'b1, 0, 0, 1'b1);
        repeat (9) apply(1'b1, 1'b0, 0, 0, 1'b1);
        apply(1'b1, 1'b1, 20, -30, 1'b0);
        check_blk(0, "clr9", 1, 0, 0, 20, -30);
        check_blk(1, "clr9", 1, 0, 0, 20, -30);
        apply(1'b1, 1'b0, 20, -30, 1'b0);
        check_blk(0, "clr9_next", 1, 0, 1, 20, -30);

        // Clear on the last block of a frame suppresses the frame strobe.
        apply(1'b0, 1'b1, 0, 0, 1'b1);
        repeat (15) apply(1'b1, 1'b0, 0, 0, 1'b1);
        apply(1'b1, 1'b1, -8, 9, 1'b0);
        check_blk(0, "clr15", 1, 0, 0, -8, 9);
        check_blk(1, "clr15", 1, 0, 0, -8, 9);

        // Asynchronous reset at count 5 with a block being presented.
        apply(1'b0, 1'b1, 0, 0, 1'b1);
        repeat (5) apply(1'b1, 1'b0, 0, 0, 1'b1);
        @(negedge clk);
        bus0.i_valid = 1'b1; bus1.i_valid = 1'b1;
        bus0.i_clear = 1'b0; bus1.i_clear = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        compare_model();
        @(posedge clk);
        #1;
        compare_model();
        @(negedge clk);
        rstn = 1'b1;
        bus0.i_valid = 1'b0; bus1.i_valid = 1'b0;
        apply(1'b0, 1'b0, 0, 0, 1'b1);
        check_blk(0, "post_rst_idle", 0, 0, 0, 0, 0);
        apply(1'b1, 1'b0, 40, 41, 1'b0);
        check_blk(0, "post_rst", 1, 0, 0, 40, 41);
        check_blk(1, "post_rst", 1, 0, 0, 40, 41);

        // Random valid/clear traffic against the model.
        repeat (300)
            apply($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
